// File: rtl/scoreboard_reg_file.sv
// Register file with a per-entry busy scoreboard, write bypass and self-clearing init.
// Reads are combinational; storage is swept to zero one entry per clock after reset.
module scoreboard_reg_file #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] qa,
  output logic [DATA_W-1:0] qb,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              wen,
  input  logic [ADDR_W-1:0] wdest,
  input  logic [DATA_W-1:0] wdata,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_reg,
  output logic              ready
);

  localparam int unsigned       DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic run_c;
  logic wr_c;
  logic claim_c;
  logic hit_a_c;
  logic hit_b_c;

  // Hard-wired zero entry: never stored, never claimed, never bypassed.
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign run_c   = rstn && (state == RUN);
  assign wr_c    = (state == RUN) && wen && !is_zero(wdest);
  assign claim_c = (state == RUN) && claim_en && !is_zero(claim_reg);
  assign hit_a_c = wen && (wdest == rs);
  assign hit_b_c = wen && (wdest == rt);

  // Read ports: bypass the in-cycle write and forward its completion to the busy flag.
  always_comb begin
    qa     = '0;
    qb     = '0;
    busy_a = 1'b0;
    busy_b = 1'b0;
    if (run_c) begin
      if (!is_zero(rs)) begin
        qa     = hit_a_c ? wdata : mem[rs];
        busy_a = busy[rs] && !hit_a_c;
      end
      if (!is_zero(rt)) begin
        qb     = hit_b_c ? wdata : mem[rt];
        busy_b = busy[rt] && !hit_b_c;
      end
    end
  end

  // Control FSM and scoreboard; a same-edge claim overrides the completing write.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= INIT;
      clr_cnt <= '0;
      busy    <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (clr_cnt == LAST) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
          end
        end
        RUN: begin
          if (wr_c)    busy[wdest]     <= 1'b0;
          if (claim_c) busy[claim_reg] <= 1'b1;
        end
        default: begin
          state <= INIT;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: init sweep or normal write-back, never reset directly.
  always_ff @(posedge clk) begin
    if (rstn) begin
      if (state == INIT) begin
        mem[clr_cnt] <= '0;
      end else if (wr_c) begin
        mem[wdest] <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_scoreboard_reg_file.sv
// Randomized self-checking bench for scoreboard_reg_file against a behavioural model.
module tb_scoreboard_reg_file;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 32;

  logic          clk = 1'b0;
  logic          rstn;
  logic [AW-1:0] rs, rt, wdest, claim_reg;
  logic [DW-1:0] qa, qb, wdata;
  logic          busy_a, busy_b, wen, claim_en, ready;

  int checks = 0;
  int errors = 0;

  scoreboard_reg_file #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk(clk), .rstn(rstn), .rs(rs), .rt(rt), .qa(qa), .qb(qb),
    .busy_a(busy_a), .busy_b(busy_b), .wen(wen), .wdest(wdest), .wdata(wdata),
    .claim_en(claim_en), .claim_reg(claim_reg), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: contents, busy set, and edges left until ready.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_busy [DEPTH];
  bit            m_ready = 1'b0;
  int            pending = 0;
  bit            checking = 1'b0;

  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
      m_ready  = 1'b0;
      pending  = DEPTH;
      checking = 1'b1;
    end else if (!m_ready) begin
      if (pending > 0) pending--;
      if (pending == 0) m_ready = 1'b1;
    end else begin
      if (wen && wdest != 0) begin
        m_mem[wdest]  = wdata;
        m_busy[wdest] = 1'b0;
      end
      if (claim_en && claim_reg != 0) m_busy[claim_reg] = 1'b1;
    end
  end

  function automatic logic [DW-1:0] exp_q(input logic [AW-1:0] a);
    if (!rstn || !m_ready || a == 0) return '0;
    if (wen && wdest == a) return wdata;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (!rstn || !m_ready || a == 0) return 1'b0;
    return m_busy[a] && !(wen && wdest == a);
  endfunction

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      chk("qa", qa, exp_q(rs));
      chk("qb", qb, exp_q(rt));
      chk("busy_a", 32'(busy_a), 32'(exp_busy(rs)));
      chk("busy_b", 32'(busy_b), 32'(exp_busy(rt)));
      chk("ready", 32'(ready), 32'(m_ready));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = 1'b0; claim_en = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; rs = '0; rt = '0; wen = 1'b0; wdest = '0; wdata = '0;
    claim_en = 1'b0; claim_reg = '0;

    // Init: two reset cycles, then ready rises on exactly the 32nd edge.
    tick(); tick();
    rstn = 1'b1;
    for (int e = 1; e <= int'(DEPTH); e++) begin
      tick();
      chk("ready_init_edge", 32'(ready), 32'(e == int'(DEPTH)));
    end
    for (int a = 0; a < int'(DEPTH); a++) begin
      rs = AW'(a); rt = AW'(DEPTH - 1 - a);
      #1;
      chk("init_zero_qa", qa, 32'h0);
      chk("init_zero_qb", qb, 32'h0);
    end

    // Write/read with bypass.
    wen = 1'b1; wdest = 5'd5; wdata = 32'h40000044; rs = 5'd5;
    #2 chk("bypass_qa", qa, 32'h40000044);
    tick(); idle();
    #2 chk("stored_qa", qa, 32'h40000044);

    // Zero register.
    wen = 1'b1; wdest = 5'd0; wdata = 32'hFFFFFFFF; rs = 5'd0;
    #2 chk("zero_bypass", qa, 32'h0);
    tick(); idle();
    #2 chk("zero_after", qa, 32'h0);
    claim_en = 1'b1; claim_reg = 5'd0;
    tick(); idle();
    #2 chk("zero_claim_busy", 32'(busy_a), 32'h0);

    // Scoreboard claim and completion forwarding.
    claim_en = 1'b1; claim_reg = 5'd9; rs = 5'd9;
    tick(); idle();
    #2 chk("claim_busy", 32'(busy_a), 32'h1);
    wen = 1'b1; wdest = 5'd9; wdata = 32'h12345678;
    #2 chk("complete_fwd_busy", 32'(busy_a), 32'h0);
    tick(); idle();
    #2 chk("complete_busy_after", 32'(busy_a), 32'h0);

    // Claim and write to the same register in one cycle.
    claim_en = 1'b1; claim_reg = 5'd7; wen = 1'b1; wdest = 5'd7; wdata = 32'h60000066;
    tick(); idle(); rs = 5'd7;
    #2 chk("collide_data", qa, 32'h60000066);
    chk("collide_busy", 32'(busy_a), 32'h1);

    // Mid-run reset wipes contents and scoreboard.
    wen = 1'b1; wdest = 5'd1; wdata = 32'hA00000AA;
    tick(); idle();
    claim_en = 1'b1; claim_reg = 5'd3;
    tick(); idle(); rs = 5'd1; rt = 5'd3;
    #2 chk("pre_reset_qa", qa, 32'hA00000AA);
    chk("pre_reset_busy_b", 32'(busy_b), 32'h1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    #1 chk("reset_ready_low", 32'(ready), 32'h0);
    for (int e = 1; e <= int'(DEPTH); e++) begin
      tick();
      chk("ready_rerun_edge", 32'(ready), 32'(e == int'(DEPTH)));
    end
    #1 chk("post_reset_qa", qa, 32'h0);
    chk("post_reset_busy_b", 32'(busy_b), 32'h0);

    // Randomized traffic with occasional resets, addresses kept in a narrow range for collisions.
    for (int c = 0; c < 3000; c++) begin
      rstn      = ($urandom_range(0, 299) != 0);
      wen       = ($urandom_range(0, 9) < 4);
      wdest     = AW'($urandom_range(0, 11));
      wdata     = $urandom;
      claim_en  = ($urandom_range(0, 9) < 3);
      claim_reg = ($urandom_range(0, 3) == 0) ? wdest : AW'($urandom_range(0, 11));
      rs        = ($urandom_range(0, 3) == 0) ? wdest : AW'($urandom_range(0, 11));
      rt        = ($urandom_range(0, 5) == 0) ? rs : AW'($urandom_range(0, 31));
      tick();
    end
    rstn = 1'b1; idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
